// File: rtl/jtsdram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jtsdram_pkg
// Purpose  : Shared definitions for the SDRAM test game traffic generators:
//            address-derived data pattern, LFSR taps, FSM encoding, timeout.
// Revision : 1.0  initial release
// ============================================================================
package jtsdram_pkg;

  // Galois feedback mask for x^22 + x^21 + 1 (right-shifting form)
  localparam logic [21:0] c_lfsr_tap = 22'h300000;

  // Default request-to-data timeout, in clock cycles
  localparam logic [9:0]  c_tout_def = 10'd1023;

  // Read-side FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_CHECK = 2'd3
  } state_t;

  // Word written at address addr of bank ba during download
  function automatic logic [15:0] exp_word(input logic [21:0] addr, input logic [1:0] ba);
    exp_word = addr[15:0] ^ {10'd0, addr[21:16]} ^ {ba, 14'd0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtsdram_lfsr22.sv
`default_nettype none
// ============================================================================
// Module   : jtsdram_lfsr22
// Purpose  : Seedable 22-bit Galois LFSR (x^22 + x^21 + 1) with advance
//            enable. Shared by the read and write generators so both walk the
//            same address stream.
// Revision : 1.0  initial release
// ============================================================================
module jtsdram_lfsr22
  import jtsdram_pkg::*;
#(
  parameter logic [21:0] SEED = 22'h3A5C1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_adv,
  output logic [21:0] o_q,
  output logic [21:0] o_nxt
);

  // Value the register will hold after the coming edge
  always_comb begin
    o_nxt = o_q;
    if (i_adv) begin
      o_nxt = {1'b0, o_q[21:1]} ^ (o_q[0] ? c_lfsr_tap : 22'd0);
    end
  end

  // State register; seed must be non-zero or the sequence locks up
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_q <= SEED;
    end else begin
      o_q <= o_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/jtsdram_bank_rd.sv
`default_nettype none
// ============================================================================
// Module   : jtsdram_bank_rd
// Purpose  : Per-bank read traffic generator and checker. Issues pseudo-random
//            32-bit reads, compares both returned words against the download
//            pattern, and keeps a sticky bad flag plus read/error counters.
// Revision : 1.0  initial release
// ============================================================================
module jtsdram_bank_rd
  import jtsdram_pkg::*;
#(
  parameter logic [1:0]  BA   = 2'd1,
  parameter int          AW   = 22,
  parameter logic [21:0] SEED = 22'h3A5C1,
  parameter logic [9:0]  TOUT = c_tout_def
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        clr,
  output logic [21:0] ba_addr,
  output logic        ba_rd,
  input  logic        ba_ack,
  input  logic        ba_rdy,
  input  logic [31:0] data_read,
  output logic        busy,
  output logic        bad,
  output logic [7:0]  err_cnt,
  output logic [15:0] rd_cnt
);

  // Word-aligned address window [0, 2^AW-2]
  localparam logic [21:0] c_addr_mask = (AW >= 22) ? 22'h3FFFFE :
                                        (((22'd1 << AW) - 22'd1) & 22'h3FFFFE);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [9:0]  r_tout;
  logic [31:0] r_data;
  logic [21:0] w_lfsr_q;
  logic [21:0] w_lfsr_nxt;
  logic [21:0] w_addr_src;
  logic        w_adv;
  logic        w_capture;
  logic        w_timeout;
  logic        w_tout_hit;
  logic        w_load_addr;
  logic        w_mismatch;
  logic        w_err;

  jtsdram_lfsr22 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .i_adv (w_adv),
    .o_q   (w_lfsr_q),
    .o_nxt (w_lfsr_nxt)
  );

  // Request and busy come straight from the state register so an async reset
  // drops ba_rd at once and nothing combinational links ba_rdy to ba_rd.
  assign ba_rd      = (r_state == ST_REQ);
  assign busy       = (r_state == ST_REQ) || (r_state == ST_WAIT);
  assign w_tout_hit = (r_tout == TOUT);

  // A new address is latched whenever REQ is entered from elsewhere; after
  // CHECK the LFSR is stepping on the same edge, so take its next value.
  assign w_load_addr = (w_state_nxt == ST_REQ) && (r_state != ST_REQ);
  assign w_addr_src  = (r_state == ST_CHECK) ? w_lfsr_nxt : w_lfsr_q;

  // The read always covers A (even) and A+1
  assign w_mismatch = (r_data[15:0]  != exp_word(ba_addr, BA)) ||
                      (r_data[31:16] != exp_word(ba_addr + 22'd1, BA));
  assign w_err      = w_timeout || ((r_state == ST_CHECK) && w_mismatch);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a same-cycle ack+rdy completes the read, otherwise
  // timeout is taken before a late ack so the counter never runs past TOUT.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_adv       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ba_ack && ba_rdy) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_CHECK;
        end else if (w_tout_hit) begin
          w_timeout   = 1'b1;
          w_adv       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (ba_ack) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ba_rdy) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_CHECK;
        end else if (w_tout_hit) begin
          w_timeout   = 1'b1;
          w_adv       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CHECK: begin
        w_adv       = 1'b1;
        w_state_nxt = enable ? ST_REQ : ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Address register and returned-data capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ba_addr <= 22'd0;
      r_data  <= 32'd0;
    end else begin
      if (w_load_addr) begin
        ba_addr <= w_addr_src & c_addr_mask;
      end
      if (w_capture) begin
        r_data <= data_read;
      end
    end
  end

  // Timeout counter: cleared on REQ entry, counts through REQ and WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tout <= 10'd0;
    end else if (w_load_addr) begin
      r_tout <= 10'd0;
    end else if (busy && !w_tout_hit) begin
      r_tout <= r_tout + 10'd1;
    end
  end

  // Statistics; clr has priority and swallows any same-cycle event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bad     <= 1'b0;
      err_cnt <= 8'd0;
      rd_cnt  <= 16'd0;
    end else if (clr) begin
      bad     <= 1'b0;
      err_cnt <= 8'd0;
      rd_cnt  <= 16'd0;
    end else begin
      if (w_err) begin
        bad <= 1'b1;
        if (err_cnt != 8'hFF) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end
      if (r_state == ST_CHECK) begin
        rd_cnt <= rd_cnt + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire
